// File: rtl/mod3_down_counter_5bit.sv
// Down-counter from TOP to 0 in steps of STEP, with wrap or one-shot stop.
// Parallel load with clamp to TOP, registered terminal-count pulse.
module mod3_down_counter_5bit #(
  parameter int WIDTH = 5,
  parameter int TOP   = 30,
  parameter int STEP  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             one_shot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] TOP_V  = WIDTH'(TOP);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic [WIDTH-1:0] ld_d;

  // Load values beyond the top of the range are clamped to TOP.
  assign ld_d = (load_val > TOP_V) ? TOP_V : load_val;

  // Single FSM: load beats enable; DONE holds at 0 until load or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      count_q <= TOP_V;
      tc_q    <= 1'b0;
    end else if (load) begin
      state_q <= RUN;
      count_q <= ld_d;
      tc_q    <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (en) begin
            if (count_q >= STEP_V) begin
              count_q <= count_q - STEP_V;
              tc_q    <= 1'b0;
            end else begin
              tc_q <= 1'b1;
              if (one_shot) begin
                count_q <= '0;
                state_q <= DONE;
              end else begin
                count_q <= TOP_V;
              end
            end
          end else begin
            tc_q <= 1'b0;
          end
        end
        DONE: begin
          count_q <= '0;
          tc_q    <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          tc_q    <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = (state_q == DONE);

endmodule
